// File: rtl/cnn_layer_accel_wht_cfg_pkg.sv
// cnn_layer_accel_wht_cfg_pkg: shared types and constants for the weight table config loader.
package cnn_layer_accel_wht_cfg_pkg;
    typedef enum logic [1:0] {IDLE, ANNOUNCE, LOAD, DONE} state_e;
    localparam int C_DEF_IN_WIDTH = 64;
    localparam int C_WEIGHT_LANES = C_DEF_IN_WIDTH / 16;
    localparam int KERNEL_3x3_WORDS = 9;
    localparam int C_DEF_MAX_KERNELS = 64;
    localparam int C_REM_W = 11;
endpackage

// File: rtl/cnn_layer_accel_wht_cfg_unpacker.sv
// cnn_layer_accel_wht_cfg_unpacker: holds one stream beat and presents its 16-bit lanes in order.
module cnn_layer_accel_wht_cfg_unpacker
    import cnn_layer_accel_wht_cfg_pkg::*;
#(
    parameter int C_IN_WIDTH = C_DEF_IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [C_IN_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  lane_valid_o,
    output logic [15:0]           lane_data_o
);
    localparam int LANES = C_IN_WIDTH / 16;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    logic [C_IN_WIDTH-1:0] buf_q, buf_d;
    logic                  full_q, full_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  last_lane, load;
    assign last_lane    = idx_q == IW'(LANES - 1);
    assign lane_valid_o = enable_i && full_q;
    assign lane_data_o  = buf_q[{idx_q, 4'b0000} +: 16];
    // A new beat may land in the same cycle the final lane is written, giving back-to-back writes.
    assign ready_o      = enable_i && !flush_i && (!full_q || last_lane);
    assign load         = valid_i && ready_o;
    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        idx_d  = idx_q;
        if (flush_i || !enable_i) begin
            full_d = 1'b0;
            idx_d  = '0;
        end else if (load) begin
            buf_d  = data_i;
            full_d = 1'b1;
            idx_d  = '0;
        end else if (lane_valid_o) begin
            full_d = !last_lane;
            idx_d  = last_lane ? '0 : IW'(idx_q + 1'b1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/cnn_layer_accel_weight_config_loader.sv
// cnn_layer_accel_weight_config_loader: streams packed weights into the CE weight table config port.
// Define CNN_LAYER_ACCEL_WHT_CFG_CHECKSUM_EN to enable the per-job wht_cfg_checksum sum.
module cnn_layer_accel_weight_config_loader
    import cnn_layer_accel_wht_cfg_pkg::*;
#(
    parameter int C_KERNEL_WORDS = KERNEL_3x3_WORDS,
    parameter int C_IN_WIDTH     = C_DEF_IN_WIDTH,
    parameter int C_MAX_KERNELS  = C_DEF_MAX_KERNELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [15:0]           cfg_num_kernels,
    input  logic                  wht_in_valid,
    output logic                  wht_in_ready,
    input  logic [C_IN_WIDTH-1:0] wht_in_data,
    output logic                  config_mode,
    output logic                  kernel_config_valid,
    output logic [15:0]           num_kernels,
    output logic                  wht_config_wren,
    output logic [15:0]           wht_config_data,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_error,
    output logic [15:0]           wht_cfg_checksum
);
    state_e               state_q, state_d;
    logic [C_REM_W-1:0]   rem_q, rem_d;
    logic [15:0]          num_q, num_d;
    logic                 err_q, err_d;
    logic                 in_load, fire, flush;
    logic [15:0]          lane_data;
    assign in_load = state_q == LOAD;
    assign flush   = fire && rem_q == C_REM_W'(1);
    cnn_layer_accel_wht_cfg_unpacker #(.C_IN_WIDTH(C_IN_WIDTH)) u_unpack (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (in_load),
        .flush_i      (flush),
        .valid_i      (wht_in_valid),
        .data_i       (wht_in_data),
        .ready_o      (wht_in_ready),
        .lane_valid_o (fire),
        .lane_data_o  (lane_data)
    );
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        num_d   = num_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cfg_start) begin
                if (cfg_num_kernels < 16'(C_MAX_KERNELS)) begin
                    num_d   = cfg_num_kernels;
                    err_d   = 1'b0;
                    state_d = ANNOUNCE;
                end else begin
                    err_d = 1'b1;
                end
            end
            ANNOUNCE: begin
                rem_d   = C_REM_W'((32'(num_q) + 32'd1) * 32'(C_KERNEL_WORDS));
                state_d = LOAD;
            end
            LOAD: if (fire) begin
                rem_d   = rem_q - 1'b1;
                state_d = flush ? DONE : LOAD;
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end
    assign config_mode         = state_q == ANNOUNCE || in_load;
    assign kernel_config_valid = state_q == ANNOUNCE;
    assign num_kernels         = num_q;
    assign wht_config_wren     = fire;
    assign wht_config_data     = fire ? lane_data : 16'h0000;
    assign cfg_busy            = state_q != IDLE;
    assign cfg_done            = state_q == DONE;
    assign cfg_error           = err_q;
`ifdef CNN_LAYER_ACCEL_WHT_CFG_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    assign sum_d = (state_q == ANNOUNCE) ? 16'h0000 : fire ? sum_q + lane_data : sum_q;
    always_ff @(posedge clk) begin
        if (rst) sum_q <= 16'h0000;
        else     sum_q <= sum_d;
    end
    assign wht_cfg_checksum = sum_q;
`else
    assign wht_cfg_checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_cnn_layer_accel_weight_config_loader.sv
// tb_cnn_layer_accel_weight_config_loader: job table plus reset sequence, writes checked against a scoreboard queue.
module tb_cnn_layer_accel_weight_config_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_num_kernels = 16'h0;
    logic        wht_in_valid = 1'b0;
    logic        wht_in_ready;
    logic [63:0] wht_in_data = 64'h0;
    logic        config_mode, kernel_config_valid, wht_config_wren;
    logic [15:0] num_kernels, wht_config_data, wht_cfg_checksum;
    logic        cfg_busy, cfg_done, cfg_error;

    cnn_layer_accel_weight_config_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_start           (cfg_start),
        .cfg_num_kernels     (cfg_num_kernels),
        .wht_in_valid        (wht_in_valid),
        .wht_in_ready        (wht_in_ready),
        .wht_in_data         (wht_in_data),
        .config_mode         (config_mode),
        .kernel_config_valid (kernel_config_valid),
        .num_kernels         (num_kernels),
        .wht_config_wren     (wht_config_wren),
        .wht_config_data     (wht_config_data),
        .cfg_busy            (cfg_busy),
        .cfg_done            (cfg_done),
        .cfg_error           (cfg_error),
        .wht_cfg_checksum    (wht_cfg_checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [15:0] base;
        int          gap;
        bit          konst;
        bit          mid;
        bit          err;
    } job_t;

    int          tests = 0;
    int          fails = 0;
    int          writes = 0;
    int          dones = 0;
    int          kcvs = 0;
    logic [15:0] exp_n = 16'h0;
    logic        prev_wren = 1'b0;
    logic [15:0] sb[$];
    job_t        jobs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lane(input job_t j, input int i);
        return j.konst ? 16'hFFFF : j.base + 16'(i);
    endfunction

    function automatic logic [63:0] beat(input job_t j, input int b);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = lane(j, b * 4 + l);
        return r;
    endfunction

    always @(negedge clk) begin
        if (wht_config_wren) begin
            writes++;
            check("mode_during_wren", {31'b0, config_mode}, 32'd1);
            if (sb.size() == 0) check("unexpected_write", {16'b0, wht_config_data}, 32'hDEAD_BEEF);
            else check("wdata", {16'b0, wht_config_data}, {16'b0, sb.pop_front()});
        end
        if (kernel_config_valid) begin
            kcvs++;
            check("kcv_num", {16'b0, num_kernels}, {16'b0, exp_n});
            check("kcv_mode", {31'b0, config_mode}, 32'd1);
        end
        if (cfg_done) begin
            dones++;
            check("done_after_last_write", {31'b0, prev_wren}, 32'd1);
            check("done_mode_low", {31'b0, config_mode}, 32'd0);
        end
        prev_wren = wht_config_wren;
    end

    task automatic run_job(input job_t j);
        int          total, nb, t;
        logic        acc;
        logic [15:0] sum;
        writes = 0; dones = 0; kcvs = 0; exp_n = j.n; sum = 16'h0;
        total = (int'(j.n) + 1) * 9;
        nb = (total + 3) / 4;
        if (!j.err) for (int i = 0; i < total; i++) begin
            sb.push_back(lane(j, i));
            sum = sum + lane(j, i);
        end
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_num_kernels = j.n;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        if (j.err) begin
            @(negedge clk); #1;
            check("err_set", {31'b0, cfg_error}, 32'd1);
            check("err_not_busy", {31'b0, cfg_busy}, 32'd0);
            repeat (4) @(posedge clk);
            #1;
            check("err_writes", writes, 0);
            check("err_no_announce", kcvs, 0);
            check("err_still_idle", {31'b0, cfg_busy}, 32'd0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            wht_in_valid = 1'b0;
            repeat (j.gap) begin @(posedge clk); #1; end
            wht_in_data = beat(j, b);
            wht_in_valid = 1'b1;
            if (j.mid && b == 1) begin cfg_start = 1'b1; cfg_num_kernels = 16'd2; end
            t = 0;
            do begin
                @(negedge clk); #1;
                acc = wht_in_ready;
                @(posedge clk); #1;
                cfg_start = 1'b0;
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                check("beat_accept_timeout", t, 0);
                break;
            end
        end
        wht_in_valid = 1'b0;
        t = 0;
        while (dones == 0 && t < 2000) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("write_count", writes, total);
        check("done_count", dones, 1);
        check("announce_count", kcvs, 1);
        check("sb_drained", sb.size(), 0);
        check("num_kernels_held", {16'b0, num_kernels}, {16'b0, j.n});
        check("busy_after_done", {31'b0, cfg_busy}, 32'd0);
        check("err_clear", {31'b0, cfg_error}, 32'd0);
`ifdef CNN_LAYER_ACCEL_WHT_CFG_CHECKSUM_EN
        check("checksum", {16'b0, wht_cfg_checksum}, {16'b0, sum});
`else
        check("checksum_off", {16'b0, wht_cfg_checksum}, 32'd0);
`endif
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        job_t rj;
        int   b, t;
        logic acc;
        jobs[0] = '{16'd0,  16'h0001, 0, 1'b0, 1'b0, 1'b0};
        jobs[1] = '{16'd3,  16'h0100, 1, 1'b0, 1'b0, 1'b0};
        jobs[2] = '{16'd64, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
        jobs[3] = '{16'd1,  16'h0200, 0, 1'b0, 1'b1, 1'b0};
        jobs[4] = '{16'd1,  16'h0000, 0, 1'b1, 1'b0, 1'b0};
        jobs[5] = '{16'd2,  16'hFFF0, 2, 1'b0, 1'b0, 1'b0};
        jobs[6] = '{16'd63, 16'h1000, 0, 1'b0, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk); #1;
        check("rst_wren", {31'b0, wht_config_wren}, 32'd0);
        check("rst_busy", {31'b0, cfg_busy}, 32'd0);
        check("rst_ready", {31'b0, wht_in_ready}, 32'd0);
        check("rst_numk", {16'b0, num_kernels}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_job(jobs[i]);
        // Abort an N=1 job after its fifth write.
        rj = '{16'd1, 16'h0300, 0, 1'b0, 1'b0, 1'b0};
        writes = 0; dones = 0; kcvs = 0; exp_n = rj.n;
        for (int i = 0; i < 18; i++) sb.push_back(lane(rj, i));
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_num_kernels = rj.n;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        b = 0; t = 0;
        wht_in_data = beat(rj, b);
        wht_in_valid = 1'b1;
        while (t < 100) begin
            @(negedge clk); #1;
            if (writes >= 5) break;
            acc = wht_in_ready;
            @(posedge clk); #1;
            if (acc) begin b++; wht_in_data = beat(rj, b); end
            t++;
        end
        rst = 1'b1;
        wht_in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("abort_writes", writes, 5);
        check("abort_wren", {31'b0, wht_config_wren}, 32'd0);
        check("abort_mode", {31'b0, config_mode}, 32'd0);
        check("abort_kcv", {31'b0, kernel_config_valid}, 32'd0);
        check("abort_numk", {16'b0, num_kernels}, 32'd0);
        check("abort_busy", {31'b0, cfg_busy}, 32'd0);
        check("abort_ready", {31'b0, wht_in_ready}, 32'd0);
        check("abort_checksum", {16'b0, wht_cfg_checksum}, 32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", dones, 0);
        run_job('{16'd1, 16'h0400, 0, 1'b0, 1'b0, 1'b0});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
